// File: rtl/alu_issue.sv
// alu_issue -- RV32I OP / OP-IMM decode and issue stage feeding the alu.
//
// Accepts one instruction per cycle over a valid/ready handshake. It decodes
// the instruction into ALU controls and reads operands from an internal
// 32 x WIDTH register file. The operation is then held in an output register
// until execute consumes it. A per-register pending scoreboard blocks issue
// while a source or destination register still awaits writeback.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     instruction handshake from fetch
//   in_instr [31:0]       raw instruction word
//   out_valid/out_ready   operation handshake to execute
//   out_fn [2:0]          ALU function (alu_fn_t, funct3 encoding)
//   out_funct7 [6:0]      ALU funct7 qualifier (funct7_t)
//   out_a, out_b [W-1:0]  ALU operands
//   out_rd [4:0]          destination register
//   wb_valid/wb_rd/wb_data  writeback into the register file
//   illegal               one-cycle pulse after an unsupported instruction is consumed
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_fn,
  output logic [6:0]       out_funct7,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [4:0]       out_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] FN_SLL     = 3'b001;
  localparam logic [2:0] FN_SRL_SRA = 3'b101;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_op_imm;
  logic       is_legal;

  assign opcode    = in_instr[6:0];
  assign rd        = in_instr[11:7];
  assign funct3    = in_instr[14:12];
  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign funct7    = in_instr[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_legal  = is_op || is_op_imm;

  // Writeback is ignored entirely while reset is asserted.
  logic wb_en;
  assign wb_en = rst_n && wb_valid;

  // Register file. Each entry is its own register so the whole file can be
  // cleared by reset. x0 is a constant zero, and writes to it are dropped.
  logic [WIDTH-1:0] rf_val [32];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_val[gi] = '0;
      end else begin : g_reg
        logic [WIDTH-1:0] reg_q;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            reg_q <= '0;
          end else if (wb_valid && (wb_rd == 5'(gi))) begin
            reg_q <= wb_data;
          end
        end
        assign rf_val[gi] = reg_q;
      end
    end
  endgenerate

  // Operand read with same-cycle writeback bypass. A source of x0 is never
  // bypassed, so a writeback aimed at x0 cannot leak into the operand.
  logic [WIDTH-1:0] src1_val;
  logic [WIDTH-1:0] src2_val;

  assign src1_val = (rs1 != 5'd0 && wb_en && wb_rd == rs1) ? wb_data : rf_val[rs1];
  assign src2_val = (rs2 != 5'd0 && wb_en && wb_rd == rs2) ? wb_data : rf_val[rs2];

  // Scoreboard. The hazard check uses the pending bits with this cycle's
  // writeback clear already applied. This lets a dependent instruction issue
  // in the same cycle as the writeback it waits on.
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] pending_eff;
  logic        hazard;
  logic        accept;

  assign clr_mask    = wb_en ? (32'd1 << wb_rd) : 32'd0;
  assign pending_eff = pending_q & ~clr_mask;

  // Illegal instructions never stall, even if their bit fields alias pending
  // registers.
  assign hazard = is_legal &&
                  (pending_eff[rs1] || (is_op && pending_eff[rs2]) || pending_eff[rd]);

  assign in_ready = rst_n && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Apply the set after the clear, so a same-cycle set and clear of one index
  // leaves the bit pending.
  assign set_mask  = (accept && is_legal) ? (32'd1 << rd) : 32'd0;
  assign pending_d = (pending_eff | set_mask) & ~32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Decode of the operation presented to execute
  logic [6:0]       dec_funct7;
  logic [WIDTH-1:0] dec_b;
  logic             is_shift;

  assign is_shift = (funct3 == FN_SLL) || (funct3 == FN_SRL_SRA);

  always_comb begin
    dec_funct7 = 7'd0;
    dec_b      = src2_val;
    if (is_op) begin
      dec_funct7 = funct7;
      dec_b      = src2_val;
    end else if (is_shift) begin
      // Immediate shifts: the upper immediate bits select SRA vs SRL, and
      // the shift amount is zero-extended.
      dec_funct7 = funct7;
      dec_b      = {{(WIDTH-5){1'b0}}, in_instr[24:20]};
    end else begin
      // Other immediate ops force funct7 to zero, so ADDI never subtracts.
      dec_funct7 = 7'd0;
      dec_b      = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    end
  end

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_fn_q, out_fn_d;
  logic [6:0]       out_funct7_q, out_funct7_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             illegal_q, illegal_d;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_fn_d     = out_fn_q;
    out_funct7_d = out_funct7_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_rd_d     = out_rd_q;
    illegal_d    = accept && !is_legal;
    if (accept && is_legal) begin
      out_valid_d  = 1'b1;
      out_fn_d     = funct3;
      out_funct7_d = dec_funct7;
      out_a_d      = src1_val;
      out_b_d      = dec_b;
      out_rd_d     = rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_fn_q     <= '0;
      out_funct7_q <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_rd_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_fn_q     <= out_fn_d;
      out_funct7_q <= out_funct7_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_rd_q     <= out_rd_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_fn     = out_fn_q;
  assign out_funct7 = out_funct7_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_rd     = out_rd_q;
  assign illegal    = illegal_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue stage directly upstream of the `alu`. Accepts 32-bit RV32I OP and OP-IMM instructions over a valid/ready handshake, decodes them into `alu_fn_t`/`funct7_t` controls, reads operands from an internal 32-entry register file, and presents a registered operation to the execute stage. Holds a per-register scoreboard so no instruction issues while a source or destination register still awaits writeback.

## Interface
- `WIDTH`, 32, datapath/register width (XLEN); matches `alu` `WIDTH`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  instruction available from fetch.
- `in_ready`  out  1  stage accepts instruction this cycle.
- `in_instr`  in  32  raw instruction word.
- `out_valid`  out  1  decoded operation valid to execute.
- `out_ready`  in  1  execute consumes operation this cycle.
- `out_fn`  out  alu_fn_t  ALU function (funct3).
- `out_funct7`  out  funct7_t  ALU funct7 qualifier.
- `out_a`, `out_b`  out  WIDTH  ALU operands.
- `out_rd`  out  5  destination register.
- `wb_valid`  in  1  writeback strobe from downstream.
- `wb_rd`  in  5  writeback register index.
- `wb_data`  in  WIDTH  writeback value.
- `illegal`  out  1  one-cycle pulse: unsupported instruction consumed.

## Operation
- Opcode `0110011` (OP): `fn`=instr[14:12], `funct7`=instr[31:25], `a`=x[rs1], `b`=x[rs2]; uses rs1, rs2.
- Opcode `0010011` (OP-IMM): `fn`=instr[14:12], `a`=x[rs1], `b`=sign-extend(instr[31:20]) to WIDTH; uses rs1 only. `funct7`=instr[31:25] only for fn SLL (001) and SRL_SRA (101); all other fns force `funct7`=`0000000` (ADDI never subtracts). For shifts, `b`=zero-extended instr[24:20].
- Any other opcode: consumed (handshake completes), no output, no scoreboard change, `illegal`=1 next cycle.
- Register file: 32 × WIDTH; x0 reads 0, writes to x0 ignored. `wb_valid` writes `wb_data` to `wb_rd` at clock edge.
- Scoreboard: 32 pending bits, bit 0 tied 0. Set for rd (≠0) when an OP/OP-IMM instruction is accepted; cleared on `wb_valid` for `wb_rd`. Same-cycle set and clear of same index: set wins. Clear of non-pending bit: no effect.
- Hazard: stall if pending[rs1], pending[rs2] (OP only), or pending[rd] (WAW) — evaluated against pending bits with the same-cycle `wb_rd` clear already applied.
- Bypass: a source equal to same-cycle `wb_rd` (≠0, `wb_valid`) reads `wb_data`, not the array.
- `in_ready` = rst_n && !hazard && (!out_valid || out_ready). Hazard computed from `in_instr` regardless of `in_valid`; illegal instructions never stall.
- Output register loads on acceptance of a legal instruction; `out_valid` clears when `out_ready` and no new acceptance. Outputs stable while `out_valid && !out_ready`.

## Timing
- Reset (rst_n=0 at edge): `out_valid`=0, `illegal`=0, `out_fn`/`out_funct7`/`out_a`/`out_b`/`out_rd`=0, all registers 0, scoreboard 0. `in_ready`=0 during reset cycle; writeback ignored while in reset. Reset mid-handshake discards held operation.
- Latency: instruction accepted at edge N → `out_valid`=1 after edge N, visible cycle N+1.
- Throughput: 1 instruction/cycle with `out_ready` held high and no hazards.
- Back-to-back dependent pair: second stalls until writeback of first; with writeback in cycle W the dependent instruction may be accepted in cycle W (bypass).
- `illegal` high exactly one cycle after the consuming edge; never asserted with reset.

## Test plan
- Reset: drive rst_n=0 two cycles with in_valid=1 → out_valid=0, in_ready=0, all outputs 0; after release, x5 reads 0.
- ADD/SUB/ADDI: wb x1=7, x2=3; issue `sub x3,x1,x2` → fn=000, funct7=0100000, a=7, b=3, rd=3; `addi x4,x1,-1` → funct7=0000000, b=0xFFFFFFFF.
- SRAI: `srai x5,x1,4` (instr[31:25]=0100000) → fn=101, funct7=0100000, b=4.
- RAW stall + bypass: issue `add x6,x1,x2`, then `add x7,x6,x6` → in_ready=0 until wb x6=10; in wb cycle accepted, a=b=10.
- Backpressure: out_ready=0 three cycles with in_valid=1 → outputs stable, in_ready=0; release → drain one per cycle.
- Illegal/x0: opcode `0000011` → consumed, illegal pulses 1 cycle, out_valid unchanged; wb x0=0xDEAD → `add x8,x0,x0` gives a=b=0, no stall.
